// File: rtl/gfx_mem_arbiter.sv
// gfx_mem_arbiter: round-robin arbiter sharing one pipelined video-memory read port
// among the sprite, BG0, BG1 and overlay clients; CPU busy cycles block issue.
module gfx_mem_arbiter #(
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BITS   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*ADDR_BITS-1:0] client_address_i,
    input  logic [3:0]             client_rvalid_i,
    output logic [4*DATA_BITS-1:0] client_data_o,
    output logic [3:0]             client_rready_o,
    output logic [ADDR_BITS-1:0]   mem_address_o,
    output logic                   mem_ren_o,
    input  logic                   mem_busy_i,
    input  logic [DATA_BITS-1:0]   mem_data_i
);
    logic [1:0]             ptr_q, ptr_d, gnt;
    logic [MEM_LATENCY-1:0] vld_q;
    logic [1:0]             tag_q [MEM_LATENCY];
    logic [3:0]             rready_q, rready_d, pend, elig;
    logic [4*DATA_BITS-1:0] data_q, data_d;
    logic                   found;

    // A client stays blocked while any read for it is in flight and during its rready cycle
    always_comb begin
        pend = '0;
        for (int s = 0; s < MEM_LATENCY; s++)
            if (vld_q[s]) pend[tag_q[s]] = 1'b1;
    end

    assign elig = client_rvalid_i & ~pend & ~rready_q;

    always_comb begin
        found = 1'b0;
        gnt   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!found && elig[ptr_q + 2'(k)]) begin
                found = 1'b1;
                gnt   = ptr_q + 2'(k);
            end
        end
    end

    assign mem_ren_o     = found & ~mem_busy_i & rst_n;
    assign mem_address_o = mem_ren_o ? client_address_i[gnt*ADDR_BITS +: ADDR_BITS] : '0;
    assign ptr_d         = mem_ren_o ? gnt + 2'd1 : ptr_q;

    always_comb begin
        rready_d = '0;
        data_d   = data_q;
        if (vld_q[MEM_LATENCY-1]) begin
            rready_d[tag_q[MEM_LATENCY-1]] = 1'b1;
            data_d[tag_q[MEM_LATENCY-1]*DATA_BITS +: DATA_BITS] = mem_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            vld_q    <= '0;
            rready_q <= '0;
            data_q   <= '0;
            for (int s = 0; s < MEM_LATENCY; s++)
                tag_q[s] <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rready_q <= rready_d;
            data_q   <= data_d;
            vld_q[0] <= mem_ren_o;
            tag_q[0] <= gnt;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign client_rready_o = rready_q;
    assign client_data_o   = data_q;
endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// tb_gfx_mem_arbiter: directed + random stimulus against a behavioural arbiter model
// and a completion scoreboard fed at issue time.
module tb_gfx_mem_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] addr;
    logic [3:0]  rvalid;
    logic [63:0] cdata;
    logic [3:0]  rready;
    logic [15:0] maddr;
    logic        mren;
    logic        busy;
    logic [15:0] mdata;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int          due;
        int          cl;
        logic [15:0] d;
    } exp_t;
    exp_t sb[$];

    logic [15:0] ta [4] = '{16'h1000, 16'h2111, 16'h3222, 16'h4333};

    gfx_mem_arbiter #(.ADDR_BITS(16), .DATA_BITS(16), .MEM_LATENCY(LAT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .client_address_i (addr),
        .client_rvalid_i  (rvalid),
        .client_data_o    (cdata),
        .client_rready_o  (rready),
        .mem_address_o    (maddr),
        .mem_ren_o        (mren),
        .mem_busy_i       (busy),
        .mem_data_i       (mdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hACDB;
    endfunction

    // Pipelined memory: data for an address issued in cycle T appears in cycle T+LAT
    logic [16:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= {mren, maddr};
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
    assign mdata = mp[LAT-1][16] ? memf(mp[LAT-1][15:0]) : 16'h0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-client lockout counters, rotating pointer, completion scoreboard
    int          cyc;
    int          cnt [4];
    logic [15:0] mdat [4];
    logic [1:0]  mptr, mc;
    int          g;
    logic        mfound, exp_ren;
    logic [3:0]  exp_rr;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ren", 64'(mren), 64'd0);
            chk("rst_addr", 64'(maddr), 64'd0);
            chk("rst_rready", 64'(rready), 64'd0);
            chk("rst_cdata", cdata, 64'd0);
            sb.delete();
            mptr = 2'd0;
            cyc  = 0;
            for (int i = 0; i < 4; i++) begin
                cnt[i]  = 0;
                mdat[i] = 16'h0;
            end
        end else begin
            exp_rr = 4'b0;
            while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                exp_rr[e.cl] = 1'b1;
                mdat[e.cl]   = e.d;
            end
            chk("rready", 64'(rready), 64'(exp_rr));
            chk("cdata", cdata, {mdat[3], mdat[2], mdat[1], mdat[0]});
            mfound = 1'b0;
            g      = int'(mptr);
            for (int k = 0; k < 4; k++) begin
                mc = mptr + 2'(k);
                if (!mfound && rvalid[mc] && cnt[mc] == 0) begin
                    mfound = 1'b1;
                    g      = int'(mc);
                end
            end
            exp_ren = mfound && !busy;
            chk("mem_ren", 64'(mren), 64'(exp_ren));
            if (exp_ren) begin
                chk("mem_addr", 64'(maddr), 64'(addr[g*16 +: 16]));
                sb.push_back('{cyc + LAT + 1, g, memf(addr[g*16 +: 16])});
                mptr = 2'(g + 1);
            end
            for (int i = 0; i < 4; i++) if (cnt[i] > 0) cnt[i]--;
            if (exp_ren) cnt[g] = LAT + 1;
            cyc++;
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        go();
        rst_n  = 1'b0;
        rvalid = 4'b0;
        busy   = 1'b0;
        go();
        go();
        rst_n = 1'b1;
    endtask

    task automatic single(input int c, input logic [15:0] a, input logic [15:0] d);
        do_reset();
        addr[c*16 +: 16] = a;
        rvalid = 4'(1 << c);
        @(negedge clk);
        chk("single_issue", 64'(mren), 64'd1);
        chk("single_addr", 64'(maddr), 64'(a));
        repeat (2) begin
            @(negedge clk);
            chk("single_noissue", 64'(mren), 64'd0);
        end
        @(negedge clk);
        chk("single_rready", 64'(rready), 64'(1 << c));
        chk("single_data", 64'(cdata[c*16 +: 16]), 64'(d));
        chk("single_hazard", 64'(mren), 64'd0);
        @(negedge clk);
        chk("single_reissue", 64'(mren), 64'd1);
        go();
        rvalid = 4'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        rvalid = 4'b0;
        busy   = 1'b0;
        addr   = '0;
        single(1, 16'h1234, 16'hBEEF);
        single(2, 16'h5678, 16'hFAA3);

        do_reset();
        for (int i = 0; i < 4; i++) addr[i*16 +: 16] = ta[i];
        rvalid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rr_issue", 64'(mren), 64'd1);
            chk("rr_addr", 64'(maddr), 64'(ta[k%4]));
            if (k >= 3) chk("rr_rready", 64'(rready), 64'(1 << ((k-3)%4)));
        end
        go();
        busy = 1'b1;
        for (int k = 12; k < 15; k++) begin
            @(negedge clk);
            chk("busy_noissue", 64'(mren), 64'd0);
            chk("busy_rready", 64'(rready), 64'(1 << ((k-3)%4)));
        end
        go();
        busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("busy_resume", 64'(maddr), 64'(ta[k]));
        end
        go();
        rvalid = 4'b0;
        repeat (5) @(negedge clk);

        do_reset();
        rvalid = 4'b1001;
        @(negedge clk);
        chk("rst_pre0", 64'(maddr), 64'(ta[0]));
        @(negedge clk);
        chk("rst_pre3", 64'(maddr), 64'(ta[3]));
        go();
        rst_n  = 1'b0;
        rvalid = 4'b1010;
        @(negedge clk);
        chk("rst_mid_rready", 64'(rready), 64'd0);
        go();
        go();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_first_grant", 64'(maddr), 64'(ta[1]));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_dropped", 64'(rready), 64'd0);
            chk("rst_cdata0", cdata, 64'd0);
        end
        @(negedge clk);
        chk("rst_post_rready", 64'(rready), 64'b0010);
        go();
        rvalid = 4'b0;
        repeat (5) @(negedge clk);

        do_reset();
        addr[15:0] = 16'h0F0F;
        rvalid = 4'b0001;
        @(negedge clk);
        chk("drop_issue", 64'(mren), 64'd1);
        go();
        rvalid = 4'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("drop_rready", 64'(rready), 64'b0001);
        chk("drop_data", 64'(cdata[15:0]), 64'h0A3D4);

        for (int n = 0; n < 400; n++) begin
            go();
            rvalid = 4'($urandom);
            busy   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) addr = {$urandom, $urandom};
        end
        go();
        rvalid = 4'b0;
        busy   = 1'b0;
        repeat (8) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
